alu_collect_pipeline: RTL and testbench
=======================================

ALU_COLLECT_PIPELINE -- requirements
Module: alu_collect_pipeline

Interface
REQ-001 SHALL have parameter XLEN, default 32, giving the datapath width; legal values are 32 and 64.
REQ-002 SHALL have parameter PRF_BANK_COUNT, default 4, giving the physical register file bank count; it is a power of 2, at least 2.
REQ-003 SHALL have parameter LOG_PR_COUNT, default 7, giving the physical register tag width.
REQ-004 SHALL have parameter LOG_ROB_ENTRIES, default 7, giving the ROB index width.
REQ-005 SHALL use one clock and a synchronous, active-high reset, with these ports:
- CLK  in  1  clock; all state updates on rising edge
- RST  in  1  synchronous active-high reset
- valid_in  in  1  issue request
- ready_out  out  1  issue accept
- op_in  in  4  {funct7[5],funct3}
- is_imm_in  in  1  B operand is imm_in
- imm_in  in  XLEN  sign-extended immediate
- A_unneeded_in  in  1  A forced to 0
- A_forward_in, B_forward_in  in  1 each  operand arrives on forward bus
- A_bank_in, B_bank_in  in  log2(PRF_BANK_COUNT) each  source bank
- dest_PR_in  in  LOG_PR_COUNT  destination tag
- ROB_index_in  in  LOG_ROB_ENTRIES  ROB index
- A_reg_read_valid_in, B_reg_read_valid_in  in  1 each  register-read data present this cycle
- reg_read_data_by_bank_in, forward_data_by_bank_in  in  PRF_BANK_COUNT x XLEN each  per-bank data
- flush_in  in  1  kill all in-flight ops
- WB_ready_in  in  1  writeback accepts
- WB_valid_out  out  1  result valid
- WB_data_out  out  XLEN  result
- WB_PR_out  out  LOG_PR_COUNT  destination tag
- WB_ROB_index_out  out  LOG_ROB_ENTRIES  ROB index

Function
REQ-006 SHALL have two stages, each with one op slot: operand collect (OC) and writeback register (WB).
REQ-007 SHALL accept an op when valid_in && ready_out at a rising edge; the op occupies OC from the next cycle (its entry cycle).
REQ-008 SHALL drive ready_out = !RST && !flush_in && (!OC_valid || OC_advance), combinationally.
REQ-009 SHALL set OC_advance = OC_valid && A_have && B_have && (!WB_valid_out || WB_ready_in).
REQ-010 SHALL source operand A as follows:
- A_unneeded: A_have = 1 and A = 0 at entry.
- A_forward: captures forward_data_by_bank_in[A_bank] in the entry cycle only.
- otherwise: captures reg_read_data_by_bank_in[A_bank] in the first OC cycle where A_reg_read_valid_in is high; the entry cycle counts.
REQ-011 SHALL source operand B by the same rules as A, except that is_imm gives B = imm_in and B_have = 1 at entry; is_imm overrides B_forward.
REQ-012 SHALL use each captured operand (combinational in the capture cycle, registered thereafter) for every later cycle of that op, so that a stall never loses data.
REQ-013 SHALL ignore reg_read_valid pulses while OC is empty or the corresponding operand is already held.
REQ-014 SHALL compute the result combinationally in the advance cycle and register it into WB with dest_PR and ROB_index. Ops:
- 0000 ADD, 1000 SUB
- x001 SLL, 0101 SRL, 1101 SRA; shift amount is B[log2(XLEN)-1:0]
- x010 SLT (signed), x011 SLTU (result 0/1, zero-extended)
- x100 XOR, x110 OR, x111 AND
REQ-015 SHALL wrap arithmetic modulo 2^XLEN, with no overflow flag.
REQ-016 SHALL hold WB_valid_out and all WB_* outputs stable while WB_valid_out && !WB_ready_in, and clear WB_valid_out after handshake unless a new result loads in the same edge.
REQ-017 SHALL give a minimum latency of 2 cycles: accepted at edge t, WB_valid_out high in the cycle after edge t+1 when operands are present in the entry cycle.
REQ-018 SHALL sustain one op per cycle when WB_ready_in=1 and operands arrive in their entry cycles.
REQ-019 SHALL, when flush_in is high at an edge, clear OC_valid and WB_valid_out, drop any issue that cycle, and leave WB_data/PR/ROB unchanged.
REQ-020 SHALL let flush_in take priority over advance and WB handshake in the same cycle.

Reset
REQ-021 SHALL, with RST high at an edge, clear OC_valid, A_have, B_have, WB_valid_out, WB_data_out, WB_PR_out and WB_ROB_index_out to 0; ready_out is 0 while RST is high.
REQ-022 SHALL discard in-flight ops on reset mid-operation; ready_out is 1 in the first cycle after RST falls.

Verification
REQ-023 SHALL cover: ADD, A forward bank 2 = 5, imm = -3, WB_ready=1 -> WB_data=2 two cycles after issue, PR/ROB match.
REQ-024 SHALL cover: SRA, A reg-read 0x80000000 arriving 3 cycles after entry, B = 4 -> ready_out low for 3 cycles, then WB_data=0xF8000000.
REQ-025 SHALL cover: back-to-back SLT(-1,1) then SLTU(-1,1) with WB_ready=0 for 2 cycles -> outputs held, ready_out low, then results 1 then 0 in order.
REQ-026 SHALL cover: flush_in while OC stalled and WB valid -> WB_valid_out=0 next cycle, the stalled op never appears, and a later op completes normally.
REQ-027 SHALL cover: XLEN=64, PRF_BANK_COUNT=8, SLL of 1 by 63 -> WB_data=0x8000000000000000.
REQ-028 SHALL cover: RST asserted with ops in OC and WB -> all outputs 0 next cycle, no WB_valid afterwards.

Source files
------------

// File: rtl/alu_collect_pipeline.sv
// rtl/alu_collect_pipeline.sv - two-stage integer ALU: operand collect slot feeding a writeback register
//
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   valid_in / ready_out          issue handshake
//   op_in                         {funct7[5], funct3}
//   is_imm_in, imm_in             B operand taken from the sign-extended immediate
//   A_unneeded_in                 A operand forced to zero
//   A_forward_in, B_forward_in    operand arrives on the forward bus in the entry cycle
//   A_bank_in, B_bank_in          source bank of each operand
//   dest_PR_in, ROB_index_in      tags carried through to writeback
//   A/B_reg_read_valid_in         register-read data for that operand is on its bank this cycle
//   reg_read_data_by_bank_in      register-read data, bank i at [i*XLEN +: XLEN]
//   forward_data_by_bank_in       forward data, bank i at [i*XLEN +: XLEN]
//   flush_in                      kill all in-flight ops
//   WB_ready_in / WB_valid_out    writeback handshake
//   WB_data_out, WB_PR_out, WB_ROB_index_out  result and its tags
module alu_collect_pipeline #(
    parameter int XLEN            = 32,
    parameter int PRF_BANK_COUNT  = 4,
    parameter int LOG_PR_COUNT    = 7,
    parameter int LOG_ROB_ENTRIES = 7
) (
    input  logic                                 CLK,
    input  logic                                 RST,
    input  logic                                 valid_in,
    output logic                                 ready_out,
    input  logic [3:0]                           op_in,
    input  logic                                 is_imm_in,
    input  logic [XLEN-1:0]                      imm_in,
    input  logic                                 A_unneeded_in,
    input  logic                                 A_forward_in,
    input  logic                                 B_forward_in,
    input  logic [$clog2(PRF_BANK_COUNT)-1:0]    A_bank_in,
    input  logic [$clog2(PRF_BANK_COUNT)-1:0]    B_bank_in,
    input  logic [LOG_PR_COUNT-1:0]              dest_PR_in,
    input  logic [LOG_ROB_ENTRIES-1:0]           ROB_index_in,
    input  logic                                 A_reg_read_valid_in,
    input  logic                                 B_reg_read_valid_in,
    input  logic [PRF_BANK_COUNT*XLEN-1:0]       reg_read_data_by_bank_in,
    input  logic [PRF_BANK_COUNT*XLEN-1:0]       forward_data_by_bank_in,
    input  logic                                 flush_in,
    input  logic                                 WB_ready_in,
    output logic                                 WB_valid_out,
    output logic [XLEN-1:0]                      WB_data_out,
    output logic [LOG_PR_COUNT-1:0]              WB_PR_out,
    output logic [LOG_ROB_ENTRIES-1:0]           WB_ROB_index_out
);

    localparam int BANK_W  = $clog2(PRF_BANK_COUNT);
    localparam int SHAMT_W = $clog2(XLEN);

    // Operand collect slot
    logic                       oc_valid;
    logic                       oc_entry;    // first cycle the op sits in OC
    logic [3:0]                 oc_op;
    logic                       oc_a_have;
    logic                       oc_a_fwd;
    logic [BANK_W-1:0]          oc_a_bank;
    logic [XLEN-1:0]            oc_a_val;
    logic                       oc_b_have;
    logic                       oc_b_fwd;
    logic [BANK_W-1:0]          oc_b_bank;
    logic [XLEN-1:0]            oc_b_val;
    logic [LOG_PR_COUNT-1:0]    oc_pr;
    logic [LOG_ROB_ENTRIES-1:0] oc_rob;

    logic [XLEN-1:0] a_fwd_data, a_reg_data, b_fwd_data, b_reg_data;
    logic            a_fwd_hit, a_rr_hit, b_fwd_hit, b_rr_hit;
    logic            a_have, b_have;
    logic [XLEN-1:0] a_cur, b_cur;
    logic            oc_advance;
    logic            accept;
    logic [XLEN-1:0] alu_result;
    logic [SHAMT_W-1:0] shamt;

    assign a_fwd_data = forward_data_by_bank_in[oc_a_bank*XLEN +: XLEN];
    assign a_reg_data = reg_read_data_by_bank_in[oc_a_bank*XLEN +: XLEN];
    assign b_fwd_data = forward_data_by_bank_in[oc_b_bank*XLEN +: XLEN];
    assign b_reg_data = reg_read_data_by_bank_in[oc_b_bank*XLEN +: XLEN];

    // Forwarded operands exist only in the entry cycle; register-read operands
    // are taken on the first read-valid pulse while the operand is still missing.
    assign a_fwd_hit = oc_valid && !oc_a_have && oc_a_fwd && oc_entry;
    assign a_rr_hit  = oc_valid && !oc_a_have && !oc_a_fwd && A_reg_read_valid_in;
    assign b_fwd_hit = oc_valid && !oc_b_have && oc_b_fwd && oc_entry;
    assign b_rr_hit  = oc_valid && !oc_b_have && !oc_b_fwd && B_reg_read_valid_in;

    assign a_have = oc_a_have || a_fwd_hit || a_rr_hit;
    assign b_have = oc_b_have || b_fwd_hit || b_rr_hit;

    assign a_cur = oc_a_have ? oc_a_val : (oc_a_fwd ? a_fwd_data : a_reg_data);
    assign b_cur = oc_b_have ? oc_b_val : (oc_b_fwd ? b_fwd_data : b_reg_data);

    assign oc_advance = oc_valid && a_have && b_have && (!WB_valid_out || WB_ready_in);
    assign ready_out  = !RST && !flush_in && (!oc_valid || oc_advance);
    assign accept     = valid_in && ready_out;

    assign shamt = b_cur[SHAMT_W-1:0];

    always_comb begin
        alu_result = '0;
        casez (oc_op)
            4'b0000: alu_result = a_cur + b_cur;
            4'b1000: alu_result = a_cur - b_cur;
            4'b?001: alu_result = a_cur << shamt;
            4'b0101: alu_result = a_cur >> shamt;
            4'b1101: alu_result = $unsigned($signed(a_cur) >>> shamt);
            4'b?010: alu_result = {{(XLEN-1){1'b0}}, ($signed(a_cur) < $signed(b_cur))};
            4'b?011: alu_result = {{(XLEN-1){1'b0}}, (a_cur < b_cur)};
            4'b?100: alu_result = a_cur ^ b_cur;
            4'b?110: alu_result = a_cur | b_cur;
            4'b?111: alu_result = a_cur & b_cur;
            default: alu_result = '0;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            oc_valid         <= 1'b0;
            oc_entry         <= 1'b0;
            oc_a_have        <= 1'b0;
            oc_b_have        <= 1'b0;
            WB_valid_out     <= 1'b0;
            WB_data_out      <= '0;
            WB_PR_out        <= '0;
            WB_ROB_index_out <= '0;
        end else begin
            if (flush_in) begin
                oc_valid <= 1'b0;
                oc_entry <= 1'b0;
            end else if (accept) begin
                oc_valid  <= 1'b1;
                oc_entry  <= 1'b1;
                oc_op     <= op_in;
                oc_a_have <= A_unneeded_in;
                oc_a_fwd  <= A_forward_in && !A_unneeded_in;
                oc_a_bank <= A_bank_in;
                oc_a_val  <= '0;
                oc_b_have <= is_imm_in;
                oc_b_fwd  <= B_forward_in && !is_imm_in;
                oc_b_bank <= B_bank_in;
                oc_b_val  <= imm_in;
                oc_pr     <= dest_PR_in;
                oc_rob    <= ROB_index_in;
            end else begin
                oc_entry <= 1'b0;
                if (oc_advance) begin
                    oc_valid <= 1'b0;
                end
                // Hold operands captured this cycle so a stall cannot lose them.
                if (a_fwd_hit || a_rr_hit) begin
                    oc_a_have <= 1'b1;
                    oc_a_val  <= a_cur;
                end
                if (b_fwd_hit || b_rr_hit) begin
                    oc_b_have <= 1'b1;
                    oc_b_val  <= b_cur;
                end
            end

            // Flush drops the valid bit only; the data/tag registers keep their value.
            if (flush_in) begin
                WB_valid_out <= 1'b0;
            end else if (oc_advance) begin
                WB_valid_out     <= 1'b1;
                WB_data_out      <= alu_result;
                WB_PR_out        <= oc_pr;
                WB_ROB_index_out <= oc_rob;
            end else if (WB_ready_in) begin
                WB_valid_out <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_collect_pipeline.sv
// tb/tb_alu_collect_pipeline.sv - scoreboard bench for alu_collect_pipeline
module tb_alu_collect_pipeline;

    logic         CLK = 1'b0;
    logic         RST;
    logic         valid_in, ready_out;
    logic [3:0]   op_in;
    logic         is_imm_in;
    logic [31:0]  imm_in;
    logic         A_unneeded_in, A_forward_in, B_forward_in;
    logic [1:0]   A_bank_in, B_bank_in;
    logic [6:0]   dest_PR_in, ROB_index_in;
    logic         A_reg_read_valid_in, B_reg_read_valid_in;
    logic [127:0] reg_bus, fwd_bus;
    logic         flush_in, WB_ready_in, WB_valid_out;
    logic [31:0]  WB_data_out;
    logic [6:0]   WB_PR_out, WB_ROB_index_out;

    logic         d_valid, d_ready;
    logic [3:0]   d_op;
    logic         d_is_imm;
    logic [63:0]  d_imm;
    logic         d_a_unneeded, d_a_fwd, d_b_fwd;
    logic [2:0]   d_a_bank, d_b_bank;
    logic [6:0]   d_pr, d_rob;
    logic         d_a_rrv, d_b_rrv;
    logic [511:0] d_reg_bus, d_fwd_bus;
    logic         d_flush, d_wb_ready, d_wb_valid;
    logic [63:0]  d_wb_data;
    logic [6:0]   d_wb_pr, d_wb_rob;

    always #5 CLK = ~CLK;

    alu_collect_pipeline dut (
        .CLK(CLK), .RST(RST), .valid_in(valid_in), .ready_out(ready_out),
        .op_in(op_in), .is_imm_in(is_imm_in), .imm_in(imm_in),
        .A_unneeded_in(A_unneeded_in), .A_forward_in(A_forward_in), .B_forward_in(B_forward_in),
        .A_bank_in(A_bank_in), .B_bank_in(B_bank_in),
        .dest_PR_in(dest_PR_in), .ROB_index_in(ROB_index_in),
        .A_reg_read_valid_in(A_reg_read_valid_in), .B_reg_read_valid_in(B_reg_read_valid_in),
        .reg_read_data_by_bank_in(reg_bus), .forward_data_by_bank_in(fwd_bus),
        .flush_in(flush_in), .WB_ready_in(WB_ready_in), .WB_valid_out(WB_valid_out),
        .WB_data_out(WB_data_out), .WB_PR_out(WB_PR_out), .WB_ROB_index_out(WB_ROB_index_out)
    );

    alu_collect_pipeline #(.XLEN(64), .PRF_BANK_COUNT(8)) dut64 (
        .CLK(CLK), .RST(RST), .valid_in(d_valid), .ready_out(d_ready),
        .op_in(d_op), .is_imm_in(d_is_imm), .imm_in(d_imm),
        .A_unneeded_in(d_a_unneeded), .A_forward_in(d_a_fwd), .B_forward_in(d_b_fwd),
        .A_bank_in(d_a_bank), .B_bank_in(d_b_bank),
        .dest_PR_in(d_pr), .ROB_index_in(d_rob),
        .A_reg_read_valid_in(d_a_rrv), .B_reg_read_valid_in(d_b_rrv),
        .reg_read_data_by_bank_in(d_reg_bus), .forward_data_by_bank_in(d_fwd_bus),
        .flush_in(d_flush), .WB_ready_in(d_wb_ready), .WB_valid_out(d_wb_valid),
        .WB_data_out(d_wb_data), .WB_PR_out(d_wb_pr), .WB_ROB_index_out(d_wb_rob)
    );

    int tests = 0;
    int fails = 0;

    typedef struct packed {
        logic [31:0] data;
        logic [6:0]  pr;
        logic [6:0]  rob;
    } exp_t;
    exp_t exp_q[$];

    typedef struct {
        logic [3:0]  op;
        int          a_mode;   // 0 unneeded, 1 forward, 2 register read
        int          b_mode;   // 0 immediate, 1 forward, 2 register read
        int          a_delay;
        int          b_delay;
        logic [1:0]  a_bank;
        logic [1:0]  b_bank;
        logic [31:0] a_val;
        logic [31:0] b_val;
        logic [6:0]  pr;
        logic [6:0]  rob;
    } rop_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference ALU written from the op table with plain arithmetic.
    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        int sh;
        logic [31:0] ones;
        sh = int'(b[4:0]);
        ones = 32'hFFFF_FFFF;
        case (op[2:0])
            3'd0: return op[3] ? a - b : a + b;
            3'd1: return a << sh;
            3'd5: begin
                if (op[3] && a[31]) return (a >> sh) | ~(ones >> sh);
                return a >> sh;
            end
            3'd2: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            3'd3: return (a < b) ? 32'd1 : 32'd0;
            3'd4: return a ^ b;
            3'd6: return a | b;
            default: return a & b;
        endcase
    endfunction

    task automatic push_exp(input logic [31:0] d, input logic [6:0] pr, input logic [6:0] rob);
        exp_t e;
        e.data = d; e.pr = pr; e.rob = rob;
        exp_q.push_back(e);
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic fill_random();
        for (int i = 0; i < 4; i++) begin
            reg_bus[i*32 +: 32] = $urandom;
            fwd_bus[i*32 +: 32] = $urandom;
        end
    endtask

    task automatic idle();
        valid_in = 0; op_in = 0; is_imm_in = 0; imm_in = 0;
        A_unneeded_in = 0; A_forward_in = 0; B_forward_in = 0;
        A_bank_in = 0; B_bank_in = 0; dest_PR_in = 0; ROB_index_in = 0;
        A_reg_read_valid_in = 0; B_reg_read_valid_in = 0; flush_in = 0;
    endtask

    // Monitor: pops the scoreboard on every handshake and checks stall stability.
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data;
    logic [6:0]  prev_pr, prev_rob;
    always @(negedge CLK) begin
        exp_t e;
        if (prev_stall) begin
            check("wb_hold_valid", WB_valid_out, 1);
            check("wb_hold_data", WB_data_out, prev_data);
            check("wb_hold_pr", WB_PR_out, prev_pr);
            check("wb_hold_rob", WB_ROB_index_out, prev_rob);
        end
        if (WB_valid_out && WB_ready_in && !flush_in && !RST) begin
            if (exp_q.size() == 0) begin
                check("wb_unexpected_valid", WB_valid_out, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", WB_data_out, e.data);
                check("sb_pr", WB_PR_out, e.pr);
                check("sb_rob", WB_ROB_index_out, e.rob);
            end
        end
        prev_stall = WB_valid_out && !WB_ready_in && !flush_in && !RST;
        prev_data  = WB_data_out;
        prev_pr    = WB_PR_out;
        prev_rob   = WB_ROB_index_out;
    end

    function automatic rop_t gen_op();
        rop_t r;
        r.op      = 4'($urandom_range(0, 15));
        r.a_mode  = $urandom_range(0, 2);
        r.b_mode  = $urandom_range(0, 2);
        r.a_delay = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        r.b_delay = ($urandom_range(0, 1) == 0) ? 0 : $urandom_range(1, 3);
        r.a_bank  = 2'($urandom_range(0, 3));
        r.b_bank  = 2'(r.a_bank + 2'($urandom_range(1, 3)));
        r.a_val   = (r.a_mode == 0) ? 32'd0 : $urandom;
        case ($urandom_range(0, 3))
            0: r.b_val = 32'd1;
            1: r.b_val = 32'd31;
            default: r.b_val = $urandom;
        endcase
        r.pr  = 7'($urandom_range(0, 127));
        r.rob = 7'($urandom_range(0, 127));
        return r;
    endfunction

    rop_t cur, nxt;
    int   k, need_k, ops_left, cyc;
    logic cur_active;
    logic a_held, b_held;

    initial begin
        RST = 1; idle(); fill_random(); WB_ready_in = 0;
        d_valid = 0; d_op = 0; d_is_imm = 0; d_imm = 0; d_a_unneeded = 0; d_a_fwd = 0; d_b_fwd = 0;
        d_a_bank = 0; d_b_bank = 0; d_pr = 0; d_rob = 0; d_a_rrv = 0; d_b_rrv = 0;
        d_reg_bus = '0; d_fwd_bus = '0; d_flush = 0; d_wb_ready = 1;

        // Reset state
        step(); step();
        @(negedge CLK);
        check("rst_ready", ready_out, 0);
        check("rst_wb_valid", WB_valid_out, 0);
        check("rst_wb_data", WB_data_out, 0);
        check("rst_wb_pr", WB_PR_out, 0);
        check("rst_wb_rob", WB_ROB_index_out, 0);
        step(); RST = 0;
        @(negedge CLK);
        check("rst_release_ready", ready_out, 1);

        // ADD: A forwarded from bank 2 = 5, imm -3
        step(); idle(); fill_random(); WB_ready_in = 1;
        valid_in = 1; op_in = 4'b0000; is_imm_in = 1; imm_in = 32'hFFFF_FFFD;
        A_forward_in = 1; A_bank_in = 2; dest_PR_in = 7'd5; ROB_index_in = 7'd9;
        push_exp(32'd2, 7'd5, 7'd9);
        @(negedge CLK); check("add_ready", ready_out, 1);
        step(); valid_in = 0; fill_random(); fwd_bus[2*32 +: 32] = 32'd5;
        @(negedge CLK); check("add_lat_entry", WB_valid_out, 0);
        step(); fill_random();
        @(negedge CLK);
        check("add_lat_valid", WB_valid_out, 1);
        check("add_data", WB_data_out, 32'd2);
        check("add_pr", WB_PR_out, 7'd5);
        check("add_rob", WB_ROB_index_out, 7'd9);

        // SRA: A read from bank 1 three cycles after entry, B = 4
        step(); idle(); fill_random();
        valid_in = 1; op_in = 4'b1101; A_bank_in = 1; is_imm_in = 1; imm_in = 32'd4;
        dest_PR_in = 7'd11; ROB_index_in = 7'd12;
        push_exp(32'hF800_0000, 7'd11, 7'd12);
        step(); valid_in = 0;
        for (int i = 0; i < 3; i++) begin
            fill_random();
            @(negedge CLK); check("sra_ready_wait", ready_out, 0);
            step();
        end
        fill_random(); A_reg_read_valid_in = 1; reg_bus[1*32 +: 32] = 32'h8000_0000;
        @(negedge CLK); check("sra_ready_arrive", ready_out, 1);
        step(); A_reg_read_valid_in = 0; fill_random();
        @(negedge CLK);
        check("sra_valid", WB_valid_out, 1);
        check("sra_data", WB_data_out, 32'hF800_0000);

        // SLT then SLTU back to back with a two-cycle writeback stall
        step(); idle(); fill_random(); WB_ready_in = 1;
        valid_in = 1; op_in = 4'b0010; A_bank_in = 0; is_imm_in = 1; imm_in = 32'd1;
        dest_PR_in = 7'd21; ROB_index_in = 7'd22;
        push_exp(32'd1, 7'd21, 7'd22);
        step(); fill_random();
        A_reg_read_valid_in = 1; reg_bus[31:0] = 32'hFFFF_FFFF;
        op_in = 4'b0011; dest_PR_in = 7'd23; ROB_index_in = 7'd24;
        push_exp(32'd0, 7'd23, 7'd24);
        @(negedge CLK); check("b2b_ready_adv", ready_out, 1);
        step(); valid_in = 0; fill_random();
        A_reg_read_valid_in = 1; reg_bus[31:0] = 32'hFFFF_FFFF; WB_ready_in = 0;
        @(negedge CLK);
        check("b2b_stall_ready", ready_out, 0);
        check("b2b_first_data", WB_data_out, 32'd1);
        step(); fill_random(); A_reg_read_valid_in = 1; WB_ready_in = 0;
        @(negedge CLK);
        check("b2b_stall2_ready", ready_out, 0);
        check("b2b_stall2_pr", WB_PR_out, 7'd21);
        step(); fill_random(); A_reg_read_valid_in = 0; WB_ready_in = 1;
        @(negedge CLK); check("b2b_release_ready", ready_out, 1);
        step(); fill_random();
        @(negedge CLK);
        check("b2b_second_valid", WB_valid_out, 1);
        check("b2b_second_data", WB_data_out, 32'd0);
        check("b2b_second_pr", WB_PR_out, 7'd23);

        // Flush with a stalled op in OC and a valid result in WB
        step(); idle(); fill_random(); WB_ready_in = 1;
        valid_in = 1; op_in = 4'b0000; A_unneeded_in = 1; is_imm_in = 1; imm_in = 32'd7;
        dest_PR_in = 7'd30; ROB_index_in = 7'd31;
        step(); fill_random();
        A_unneeded_in = 0; op_in = 4'b0100; A_bank_in = 3; dest_PR_in = 7'd32; ROB_index_in = 7'd33;
        @(negedge CLK); check("flush_setup_ready", ready_out, 1);
        step(); valid_in = 0; WB_ready_in = 0; flush_in = 1; fill_random();
        @(negedge CLK);
        check("flush_wb_before", WB_valid_out, 1);
        check("flush_ready", ready_out, 0);
        step(); flush_in = 0; WB_ready_in = 1; fill_random(); A_reg_read_valid_in = 1;
        valid_in = 1; op_in = 4'b0110; A_forward_in = 1; A_bank_in = 1; is_imm_in = 1; imm_in = 32'h0F;
        dest_PR_in = 7'd34; ROB_index_in = 7'd35;
        push_exp(32'hFF, 7'd34, 7'd35);
        @(negedge CLK);
        check("flush_wb_cleared", WB_valid_out, 0);
        check("flush_wb_data_kept", WB_data_out, 32'd7);
        check("flush_after_ready", ready_out, 1);
        step(); valid_in = 0; fill_random(); A_reg_read_valid_in = 0; fwd_bus[1*32 +: 32] = 32'hF0;
        @(negedge CLK); check("flush_next_idle", WB_valid_out, 0);
        step(); fill_random(); A_reg_read_valid_in = 1;
        @(negedge CLK);
        check("flush_next_valid", WB_valid_out, 1);
        check("flush_next_data", WB_data_out, 32'hFF);

        // Reset with ops in OC and WB
        step(); idle(); fill_random(); WB_ready_in = 1;
        valid_in = 1; op_in = 4'b0000; A_unneeded_in = 1; is_imm_in = 1; imm_in = 32'd3;
        dest_PR_in = 7'd40; ROB_index_in = 7'd41;
        step(); A_unneeded_in = 0; A_bank_in = 2; dest_PR_in = 7'd42; ROB_index_in = 7'd43;
        step(); valid_in = 0; WB_ready_in = 0; RST = 1;
        @(negedge CLK);
        check("midrst_ready", ready_out, 0);
        check("midrst_wb_before", WB_valid_out, 1);
        step(); RST = 0;
        @(negedge CLK);
        check("midrst_wb_valid", WB_valid_out, 0);
        check("midrst_wb_data", WB_data_out, 0);
        check("midrst_wb_pr", WB_PR_out, 0);
        check("midrst_wb_rob", WB_ROB_index_out, 0);
        check("midrst_ready_after", ready_out, 1);
        WB_ready_in = 1;
        for (int i = 0; i < 4; i++) begin
            step(); fill_random(); A_reg_read_valid_in = 1;
            @(negedge CLK); check("midrst_no_valid", WB_valid_out, 0);
        end

        // Randomized traffic
        step(); idle();
        nxt = gen_op(); cur = nxt; cur_active = 0; k = 0; need_k = 0;
        ops_left = 300; cyc = 0;
        while ((ops_left > 0 || exp_q.size() > 0) && cyc < 8000) begin
            if (cyc > 0) step();
            cyc++;
            WB_ready_in = ($urandom_range(0, 9) < 7);
            fill_random();
            A_reg_read_valid_in = 0; B_reg_read_valid_in = 0;
            if (!cur_active) begin
                A_reg_read_valid_in = ($urandom_range(0, 3) == 0);
                B_reg_read_valid_in = ($urandom_range(0, 3) == 0);
            end else begin
                a_held = (cur.a_mode == 0) || (cur.a_mode == 1 && k > 0) || (cur.a_mode == 2 && k > cur.a_delay);
                b_held = (cur.b_mode == 0) || (cur.b_mode == 1 && k > 0) || (cur.b_mode == 2 && k > cur.b_delay);
                if (cur.a_mode == 1 && k == 0) fwd_bus[cur.a_bank*32 +: 32] = cur.a_val;
                if (cur.a_mode == 2 && k == cur.a_delay) begin
                    A_reg_read_valid_in = 1; reg_bus[cur.a_bank*32 +: 32] = cur.a_val;
                end else if (a_held) begin
                    A_reg_read_valid_in = ($urandom_range(0, 2) == 0);
                end
                if (cur.b_mode == 1 && k == 0) fwd_bus[cur.b_bank*32 +: 32] = cur.b_val;
                if (cur.b_mode == 2 && k == cur.b_delay) begin
                    B_reg_read_valid_in = 1; reg_bus[cur.b_bank*32 +: 32] = cur.b_val;
                end else if (b_held) begin
                    B_reg_read_valid_in = ($urandom_range(0, 2) == 0);
                end
            end
            valid_in = (ops_left > 0) && ($urandom_range(0, 9) < 8);
            op_in = nxt.op;
            A_unneeded_in = (nxt.a_mode == 0);
            A_forward_in = (nxt.a_mode == 1) || (nxt.a_mode == 0 && $urandom_range(0, 1) == 1);
            is_imm_in = (nxt.b_mode == 0);
            B_forward_in = (nxt.b_mode == 1) || (nxt.b_mode == 0 && $urandom_range(0, 1) == 1);
            imm_in = (nxt.b_mode == 0) ? nxt.b_val : $urandom;
            A_bank_in = nxt.a_bank; B_bank_in = nxt.b_bank;
            dest_PR_in = nxt.pr; ROB_index_in = nxt.rob;
            @(negedge CLK);
            if (cur_active && k < need_k) check("rand_ready_wait", ready_out, 0);
            if (valid_in && ready_out) begin
                push_exp(alu_ref(nxt.op, nxt.a_val, nxt.b_val), nxt.pr, nxt.rob);
                cur = nxt; cur_active = 1; k = 0;
                need_k = 0;
                if (cur.a_mode == 2 && cur.a_delay > need_k) need_k = cur.a_delay;
                if (cur.b_mode == 2 && cur.b_delay > need_k) need_k = cur.b_delay;
                ops_left--;
                nxt = gen_op();
            end else begin
                k++;
            end
        end
        check("rand_drained", exp_q.size(), 0);
        check("rand_ops_issued", ops_left, 0);

        // 64-bit instance: SLL of 1 by 63
        step(); idle();
        d_valid = 1; d_op = 4'b0001; d_is_imm = 1; d_imm = 64'd63;
        d_a_fwd = 1; d_a_bank = 3'd5; d_pr = 7'd50; d_rob = 7'd51;
        @(negedge CLK); check("x64_ready", d_ready, 1);
        step(); d_valid = 0; d_fwd_bus[5*64 +: 64] = 64'd1;
        step(); d_fwd_bus = '0;
        @(negedge CLK);
        check("x64_valid", d_wb_valid, 1);
        check("x64_sll_data", d_wb_data, 64'h8000_0000_0000_0000);
        check("x64_pr", d_wb_pr, 7'd50);

        step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
